// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/EX memory-port arbiter.
// Any file that needs these imports the package with a wildcard import.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled together.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  // instruction-fetch requester
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  // data requester
  logic                data_req;
  logic                data_wr;
  logic [1:0]          data_size;
  logic [DATA_W/8-1:0] data_wstrb;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W-1:0]   data_wdata;
  logic                data_addr_ok;
  logic                data_data_ok;
  logic [DATA_W-1:0]   data_rdata;
  // shared memory port
  logic                mem_req;
  logic                mem_wr;
  logic [1:0]          mem_size;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_addr_ok;
  logic                mem_data_ok;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Priority decision between the two requesters plus the saturating counter
// that forces an inst grant after STARVE_LIMIT back-to-back data grants.
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic inst_req,
  input  logic data_req,
  input  logic grant,
  output logic grant_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign grant_data = data_req && ((cnt_q < LIMIT) || !inst_req);

  // Only a data grant that bypasses a waiting fetch counts toward starvation.
  always_comb begin
    cnt_d = cnt_q;
    if (grant) begin
      if (grant_data && inst_req) begin
        cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sram-like memory port between instruction fetch and data access,
// with at most one transaction outstanding and flush-dropping of fetch data.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  mem_port_arbiter_if.slave  bus
);

  localparam int SW = DATA_W / 8;

  state_e              state_q;
  owner_e              owner_q;
  logic                drop_q;
  logic                rst_dly_q;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [SW-1:0]       wstrb_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic out_en;
  logic grant;
  logic grant_data;
  logic in_resp;

  // Outputs stay silent during reset and for one cycle after it.
  assign out_en  = !reset && !rst_dly_q;
  assign grant   = out_en && (state_q == IDLE) && (bus.inst_req || bus.data_req);
  assign in_resp = out_en && (state_q == RESP);

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .inst_req   (bus.inst_req),
    .data_req   (bus.data_req),
    .grant      (grant),
    .grant_data (grant_data)
  );

  always_ff @(posedge clk) begin
    rst_dly_q <= reset;
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_INST;
      drop_q  <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_q <= REQ;
            drop_q  <= 1'b0;
            if (grant_data) begin
              owner_q <= OWN_DATA;
              wr_q    <= bus.data_wr;
              size_q  <= bus.data_size;
              wstrb_q <= bus.data_wstrb;
              addr_q  <= bus.data_addr;
              wdata_q <= bus.data_wdata;
            end else begin
              owner_q <= OWN_INST;
              wr_q    <= 1'b0;
              size_q  <= SZ_WORD;
              wstrb_q <= '0;
              addr_q  <= bus.inst_addr;
              wdata_q <= '0;
            end
          end
        end
        REQ: begin
          if (flush && (owner_q == OWN_INST)) drop_q <= 1'b1;
          if (bus.mem_addr_ok) state_q <= RESP;
        end
        RESP: begin
          if (flush && (owner_q == OWN_INST)) drop_q <= 1'b1;
          // Memory still finishes a flushed fetch; only its delivery is dropped.
          if (bus.mem_data_ok) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.inst_addr_ok = grant && !grant_data;
  assign bus.data_addr_ok = grant && grant_data;

  assign bus.inst_data_ok = in_resp && (owner_q == OWN_INST) && !drop_q && bus.mem_data_ok;
  assign bus.data_data_ok = in_resp && (owner_q == OWN_DATA) && bus.mem_data_ok;
  assign bus.inst_rdata   = (in_resp && (owner_q == OWN_INST)) ? bus.mem_rdata : '0;
  assign bus.data_rdata   = (in_resp && (owner_q == OWN_DATA)) ? bus.mem_rdata : '0;

  assign bus.mem_req   = out_en && (state_q == REQ);
  assign bus.mem_wr    = out_en ? wr_q    : 1'b0;
  assign bus.mem_size  = out_en ? size_q  : '0;
  assign bus.mem_wstrb = out_en ? wstrb_q : '0;
  assign bus.mem_addr  = out_en ? addr_q  : '0;
  assign bus.mem_wdata = out_en ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter, checked every cycle
// against a transaction-level model of the port's sharing rules.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: one outstanding transaction described as a record.
  bit          m_busy;
  bit          m_sent;
  bit          m_own_data;
  bit          m_drop;
  bit          m_post_rst;
  int          m_starve;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  string       grant_log;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit en;
    bit idle_req;
    bit gd;
    bit resp;
    en       = !reset && !m_post_rst;
    idle_req = en && !m_busy && (bus.inst_req || bus.data_req);
    gd       = bus.data_req && ((m_starve < LIMIT) || !bus.inst_req);
    resp     = en && m_busy && m_sent;
    chk("inst_addr_ok", bus.inst_addr_ok, idle_req && !gd);
    chk("data_addr_ok", bus.data_addr_ok, idle_req && gd);
    chk("inst_data_ok", bus.inst_data_ok, resp && !m_own_data && !m_drop && bus.mem_data_ok);
    chk("data_data_ok", bus.data_data_ok, resp && m_own_data && bus.mem_data_ok);
    chk("inst_rdata", bus.inst_rdata, (resp && !m_own_data) ? bus.mem_rdata : 32'h0);
    chk("data_rdata", bus.data_rdata, (resp && m_own_data) ? bus.mem_rdata : 32'h0);
    chk("mem_req", bus.mem_req, en && m_busy && !m_sent);
    chk("mem_wr", bus.mem_wr, en ? m_wr : 1'b0);
    chk("mem_size", bus.mem_size, en ? m_size : 2'd0);
    chk("mem_wstrb", bus.mem_wstrb, en ? m_wstrb : 4'd0);
    chk("mem_addr", bus.mem_addr, en ? m_addr : 32'h0);
    chk("mem_wdata", bus.mem_wdata, en ? m_wdata : 32'h0);
    if (bus.inst_addr_ok === 1'b1) begin
      grant_log = {grant_log, "I"};
      $display("txn: inst grant addr=%h", bus.inst_addr);
    end
    if (bus.data_addr_ok === 1'b1) begin
      grant_log = {grant_log, "D"};
      $display("txn: data grant wr=%0d addr=%h", bus.data_wr, bus.data_addr);
    end
  endtask

  task automatic model_update();
    bit en;
    bit gd;
    if (reset) begin
      m_busy = 0; m_sent = 0; m_own_data = 0; m_drop = 0; m_starve = 0;
      m_wr = 0; m_size = 0; m_wstrb = 0; m_addr = 0; m_wdata = 0;
      m_post_rst = 1;
      return;
    end
    en = !m_post_rst;
    m_post_rst = 0;
    if (en && !m_busy && (bus.inst_req || bus.data_req)) begin
      gd = bus.data_req && ((m_starve < LIMIT) || !bus.inst_req);
      if (gd) begin
        m_wr = bus.data_wr; m_size = bus.data_size; m_wstrb = bus.data_wstrb;
        m_addr = bus.data_addr; m_wdata = bus.data_wdata;
        m_starve = bus.inst_req ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
      end else begin
        m_wr = 0; m_size = 2; m_wstrb = 0; m_addr = bus.inst_addr; m_wdata = 0;
        m_starve = 0;
      end
      m_own_data = gd; m_busy = 1; m_sent = 0; m_drop = 0;
    end else if (m_busy) begin
      if (flush && !m_own_data) m_drop = 1;
      if (!m_sent) begin
        if (bus.mem_addr_ok) m_sent = 1;
      end else if (bus.mem_data_ok) begin
        m_busy = 0; m_sent = 0; m_drop = 0;
      end
    end
  endtask

  task automatic settle();
    #1;
    check_outputs();
  endtask

  task automatic advance();
    model_update();
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    flush = 0;
    bus.inst_req = 0; bus.inst_addr = '0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_size = '0; bus.data_wstrb = '0;
    bus.data_addr = '0; bus.data_wdata = '0;
    bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = '0;
  endtask

  // Memory side: accept after addr_wait idle cycles, respond one cycle later.
  task automatic serve(input int addr_wait);
    for (int i = 0; i < addr_wait; i++) step();
    bus.mem_addr_ok = 1;
    step();
    bus.mem_addr_ok = 0;
    bus.mem_data_ok = 1;
    bus.mem_rdata   = $urandom;
    step();
    bus.mem_data_ok = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    idle_inputs();
    grant_log = "";
    @(negedge clk);
    step();
    step();
    reset = 0;
    step();

    // Single fetch
    bus.inst_req = 1; bus.inst_addr = 32'hBFC00000;
    settle();
    chk("fetch_addr_ok", bus.inst_addr_ok, 1);
    advance();
    bus.inst_req = 0;
    settle();
    chk("fetch_mem_req_c1", bus.mem_req, 1);
    chk("fetch_mem_addr", bus.mem_addr, 32'hBFC00000);
    advance();
    bus.mem_addr_ok = 1;
    settle();
    chk("fetch_mem_req_c2", bus.mem_req, 1);
    advance();
    bus.mem_addr_ok = 0; bus.mem_data_ok = 1; bus.mem_rdata = 32'h3C1D0001;
    settle();
    chk("fetch_data_ok", bus.inst_data_ok, 1);
    chk("fetch_rdata", bus.inst_rdata, 32'h3C1D0001);
    chk("fetch_no_data_side", bus.data_data_ok, 0);
    advance();
    bus.mem_data_ok = 0;

    // Simultaneous requests: store wins, fetch follows in the next IDLE
    bus.inst_req = 1; bus.inst_addr = 32'hBFC00004;
    bus.data_req = 1; bus.data_wr = 1; bus.data_size = 2'd1; bus.data_wstrb = 4'b0011;
    bus.data_addr = 32'h80001004; bus.data_wdata = 32'h0000BEEF;
    settle();
    chk("simul_data_first", bus.data_addr_ok, 1);
    chk("simul_inst_wait", bus.inst_addr_ok, 0);
    advance();
    bus.data_req = 0;
    settle();
    chk("simul_mem_wr", bus.mem_wr, 1);
    chk("simul_mem_wstrb", bus.mem_wstrb, 4'b0011);
    chk("simul_mem_size", bus.mem_size, 2'd1);
    advance();
    serve(0);
    settle();
    chk("simul_inst_next", bus.inst_addr_ok, 1);
    advance();
    bus.inst_req = 0;
    serve(0);

    // Starvation bound: data held high with a fetch pending
    grant_log = "";
    bus.inst_req = 1; bus.data_req = 1; bus.data_wr = 0; bus.data_size = 2'd2;
    for (int k = 0; k < 6; k++) begin
      bus.data_addr = 32'h80000100 + 32'(k * 4);
      step();
      serve(0);
    end
    n_assert++;
    assert (grant_log == "DDDDID") else begin
      n_fail++;
      $error("FAIL starve_order: observed %s expected DDDDID", grant_log);
    end
    bus.inst_req = 0; bus.data_req = 0;

    // Flush while a fetch is in RESP
    bus.inst_req = 1; bus.inst_addr = 32'hBFC00100;
    step();
    bus.inst_req = 0; bus.mem_addr_ok = 1;
    step();
    bus.mem_addr_ok = 0; flush = 1;
    step();
    flush = 0; bus.mem_data_ok = 1; bus.mem_rdata = 32'h12345678;
    settle();
    chk("flush_drop", bus.inst_data_ok, 0);
    advance();
    bus.mem_data_ok = 0;
    bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h80000200;
    settle();
    chk("flush_then_data", bus.data_addr_ok, 1);
    advance();
    bus.data_req = 0;
    serve(0);

    // Reset while in REQ, stray response afterwards
    bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h80000300; bus.data_wdata = 32'hA5A5A5A5;
    bus.data_wstrb = 4'hF;
    step();
    bus.data_req = 0;
    step();
    reset = 1;
    settle();
    chk("rst_mem_req", bus.mem_req, 0);
    advance();
    reset = 0;
    step();
    bus.mem_data_ok = 1; bus.mem_rdata = 32'hDEADBEEF;
    settle();
    chk("rst_stray_data", bus.data_data_ok, 0);
    chk("rst_stray_inst", bus.inst_data_ok, 0);
    advance();
    bus.mem_data_ok = 0;
    settle();
    chk("rst_stays_idle", bus.mem_req, 0);
    advance();

    // Slow memory acceptance: request fields held, no second grant
    bus.data_req = 1; bus.data_wr = 1; bus.data_size = 2'd2; bus.data_wstrb = 4'b1100;
    bus.data_addr = 32'h80002008; bus.data_wdata = 32'hCAFEF00D;
    step();
    bus.data_req = 0; bus.inst_req = 1; bus.inst_addr = 32'hBFC00200;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("slow_addr", bus.mem_addr, 32'h80002008);
      chk("slow_wdata", bus.mem_wdata, 32'hCAFEF00D);
      chk("slow_wstrb", bus.mem_wstrb, 4'b1100);
      chk("slow_no_grant", {bus.inst_addr_ok, bus.data_addr_ok}, 0);
      advance();
    end
    serve(0);
    step();
    bus.inst_req = 0;
    serve(1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset            = ($urandom_range(0, 149) == 0);
      flush            = ($urandom_range(0, 9) == 0);
      bus.inst_req     = ($urandom_range(0, 2) != 0);
      bus.inst_addr    = $urandom;
      bus.data_req     = ($urandom_range(0, 2) != 0);
      bus.data_wr      = $urandom_range(0, 1);
      bus.data_size    = 2'($urandom_range(0, 2));
      bus.data_wstrb   = 4'($urandom);
      bus.data_addr    = $urandom;
      bus.data_wdata   = $urandom;
      bus.mem_addr_ok  = $urandom_range(0, 1);
      bus.mem_data_ok  = $urandom_range(0, 1);
      bus.mem_rdata    = $urandom;
      step();
    end

    reset = 0;
    idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single sram-like memory port between the instruction-fetch requester and the data-access requester (EX-stage loads/stores).
- Holds at most one transaction outstanding. Data requests have priority, bounded by an anti-starvation counter.
- WB exception flush discards an in-flight instruction-fetch response.
- Sits between the IF/EX stages and the memory bridge.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is pending before one inst grant is forced.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- flush  in  1  WB exception pulse; cancels delivery of an outstanding inst response.
- inst_req  in  1  fetch request.
- inst_addr  in  ADDR_W  fetch address.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch data valid this cycle.
- inst_rdata  out  DATA_W  fetch data.
- data_req  in  1  data request.
- data_wr  in  1  1 = store.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_wstrb  in  DATA_W/8  byte enables.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_addr_ok  out  1  data request accepted.
- data_data_ok  out  1  load data valid or store complete.
- data_rdata  out  DATA_W  load data.
- mem_req  out  1  request to memory.
- mem_wr  out  1  write.
- mem_size  out  2  size.
- mem_wstrb  out  DATA_W/8  byte enables.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  DATA_W  write data.
- mem_addr_ok  in  1  memory accepted the request.
- mem_data_ok  in  1  memory response.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset drives state to IDLE. The following clear to 0: owner, drop flag, starve counter, and all latched request fields.
- Every output reads 0 while reset is high and in the cycle after reset.
- FSM states:
  - IDLE: no transaction.
  - REQ: mem_req = 1, driving the latched fields.
  - RESP: waiting for mem_data_ok.
- IDLE grant:
  - If data_req and (starve_cnt < STARVE_LIMIT or !inst_req): grant data.
  - Else if inst_req: grant inst.
  - The granted requester's addr_ok = 1 combinationally in that cycle. Request fields are latched, the owner is recorded, and the FSM goes to REQ.
  - The non-granted addr_ok = 0.
- addr_ok is never asserted outside IDLE.
- Inst transactions are forced to wr = 0, size = 2, wstrb = 0, wdata = 0.
- Starve counter:
  - Increments on a data grant while inst_req = 1, saturating at STARVE_LIMIT.
  - Clears on any inst grant, or on a data grant while inst_req = 0.
- REQ:
  - mem_req = 1 with latched fields held stable.
  - On mem_addr_ok, go to RESP; mem_req drops the next cycle.
- RESP:
  - On mem_data_ok, go to IDLE.
  - The owner's data_ok = mem_data_ok (combinational). rdata = mem_rdata, routed to the owner.
  - The non-owner's data_ok = 0 and its rdata = 0.
- Minimum latency: grant cycle N, mem_req in N+1, earliest data_ok in N+2 (addr_ok and data_ok both one-cycle).
- Back-to-back operation: a new grant can occur in the IDLE cycle after the RESP-to-IDLE transition, so sustained throughput is 1 transaction per 3 cycles.
- flush:
  - If asserted while owner = inst and state is REQ or RESP, set the drop flag. The request still completes on the memory side, but inst_data_ok is suppressed for that response. The drop flag clears on return to IDLE.
  - flush in IDLE, or with owner = data, has no effect. Stores are never cancelled.
  - flush in the same IDLE cycle as an inst grant does not cancel that grant; the requester must deassert inst_req.
- mem_data_ok or mem_addr_ok in the wrong state (IDLE, or data_ok in REQ) is ignored. This covers stale responses after a mid-transaction reset.
- Reset mid-transaction abandons the transaction immediately; no data_ok is produced.
- data_wstrb is forwarded unchanged; size/strobe consistency is the requester's responsibility.

Decomposition:
- Shared package defines:
  - state encoding IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2;
  - owner encoding OWN_INST = 1'b0, OWN_DATA = 1'b1;
  - size constants SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2.
- One natural sub-module: arb_starve_ctr, the saturating starve counter plus priority decision (inputs inst_req, data_req, grant strobe; output grant_data).

Test Plan:
- Single fetch inst_addr = 0xBFC00000, mem_addr_ok one cycle later, mem_data_ok with rdata = 0x3C1D0001 -> inst_addr_ok at cycle 0; mem_req in cycles 1–2; inst_data_ok = 1 with inst_rdata = 0x3C1D0001; data_data_ok stays 0.
- Simultaneous inst_req and data_req (store addr 0x80001004, wstrb = 4'b0011, size = 1) -> data granted first with mem_wr = 1, mem_wstrb = 0011, mem_size = 1; inst granted in the next IDLE.
- data_req held high for 6 transactions while inst_req is high, STARVE_LIMIT = 4 -> grant order is D, D, D, D, I, D.
- Fetch in RESP, flush pulse, then mem_data_ok -> inst_data_ok stays 0; FSM returns to IDLE; next data request granted normally.
- Reset asserted while in REQ, then a stray mem_data_ok two cycles later -> all outputs 0; no data_ok on either side; FSM stays IDLE.
- mem_addr_ok delayed 5 cycles -> mem_addr, mem_wdata and mem_wstrb are stable throughout; no second addr_ok is given to either requester.
